// File: rtl/ssd_bcd_converter.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one bit per cycle.
// Optional leading-zero blank mask enabled by defining SSD_LEADING_BLANK_EN.
module ssd_bcd_converter #(
    parameter int IN_W   = 13,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [IN_W-1:0]       num,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [DIGITS-1:0]     blank
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(IN_W + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FINISH
    } state_t;

    state_t          state_q, state_d;
    logic [IN_W-1:0] shift_q, shift_d;
    logic [BW-1:0]   scratch_q, scratch_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [BW-1:0]   bcd_q, bcd_d;
    logic            done_q, done_d;
    logic [BW-1:0]   adj;

    // Add-3 correction on every digit in parallel, ahead of the shift.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
        assign adj[4*gi +: 4] = (scratch_q[4*gi +: 4] >= 4'd5) ?
                                (scratch_q[4*gi +: 4] + 4'd3) :
                                scratch_q[4*gi +: 4];
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        bcd_d     = bcd_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    shift_d   = num;
                    scratch_d = '0;
                    cnt_d     = CW'(IN_W);
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                {scratch_d, shift_d} = {adj, shift_q} << 1;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                bcd_d   = scratch_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            bcd_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            bcd_q     <= bcd_d;
            done_q    <= done_d;
        end
    end

    assign busy = (state_q == SHIFT);
    assign done = done_q;
    assign bcd  = bcd_q;

`ifdef SSD_LEADING_BLANK_EN
    logic [DIGITS-1:0] digit_zero;
    logic [DIGITS-1:0] blank_calc;
    logic [DIGITS-1:0] blank_q, blank_d;

    // Digit 0 is never blanked so a zero value still shows "0".
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_blank
        assign digit_zero[gi] = (scratch_q[4*gi +: 4] == 4'd0);
        if (gi == 0) begin : g_ones
            assign blank_calc[gi] = 1'b0;
        end else begin : g_upper
            assign blank_calc[gi] = &digit_zero[DIGITS-1:gi];
        end
    end

    always_comb begin
        blank_d = blank_q;
        if (state_q == FINISH) begin
            blank_d = blank_calc;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blank_q <= '0;
        end else begin
            blank_q <= blank_d;
        end
    end

    assign blank = blank_q;
`else
    assign blank = '0;
`endif

endmodule
